seq_shift_unit: RTL and testbench
=================================

# seq_shift_unit

- Multi-cycle, handshaked shift/rotate engine for signed 8-bit operands.
- Covers both shift directions (logical/arithmetic left and right, rotate left and right) as the sequential counterpart of the team's combinational shift logic.
- Shifts one bit position per clock, so datapaths that cannot afford a full barrel shifter share this unit through a valid/ready interface.
- Optionally saturates arithmetic left shifts and flags overflow.

## Interface
- `WIDTH`, default 8: operand width. Must be a power of two, ≥ 4.
- `AMT_W`, default 3: shift-amount width. Must equal log2(WIDTH).
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request.
- `in_data` input WIDTH, signed: operand.
- `in_amt` input AMT_W: shift amount, 0..WIDTH-1.
- `in_op` input 3: operation code.
  - 0 SLL, 1 SRL, 2 SRA, 3 SLA, 4 ROL, 5 ROR.
  - 6 and 7 are reserved and act as pass-through.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts result.
- `out_data` output WIDTH, signed: result.
- `out_ovf` output 1: SLA overflow flag. Meaningful only with `SHIFT_SAT_EN`.

## Operation
- **FSM states:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready` = 1 when `rst` = 0.
  - On `in_valid && in_ready`, capture data, op, original sign bit and cnt = `in_amt`, and clear the overflow flag.
  - If `in_amt` = 0, go to DONE. Otherwise go to SHIFT.
- **SHIFT**
  - Each cycle applies one single-bit step of op to the working register and decrements cnt.
  - When cnt reaches 0, go to DONE.
  - `in_ready` = 0 and `out_valid` = 0.
- **Single-bit steps**
  - SLL: {r[W-2:0], 0}.
  - SRL: {0, r[W-1:1]}.
  - SRA: {r[W-1], r[W-1:1]}.
  - SLA: same as SLL (see Configuration).
  - ROL: {r[W-2:0], r[W-1]}.
  - ROR: {r[0], r[W-1:1]}.
  - Reserved ops: register unchanged, but still spend amt cycles.
- **DONE**
  - `out_valid` = 1; `out_data` and `out_ovf` are held stable.
  - On `out_ready`, go to IDLE.
  - No new request is accepted in DONE (`in_ready` = 0).
- **Reset**
  - All outputs are registered except `in_ready` = (state == IDLE) && !`rst`.
  - Reset values: `out_valid` = 0, `out_data` = 0, `out_ovf` = 0, `in_ready` = 0 while `rst` is high.
- **Reset mid-operation:** abort, go to IDLE and discard the operand. No partial result is emitted.
- **Amount range:** `in_amt` is used modulo its width; no amount ≥ WIDTH exists.

## Timing
- **Latency:**
  - Accept at edge k.
  - Shift steps occur at edges k+1 … k+amt.
  - `out_valid` rises after edge k+amt; amt = 0 means after edge k.
- **Throughput:**
  - One result per amt+2 cycles when `out_ready` is held high.
  - Consumer stalls extend DONE indefinitely.
- **Handshake:** `out_valid` must not drop and `out_data` must not change until `out_ready` is sampled high.
- **No combinational path** from `in_valid`/`out_ready` to any output.

## Configuration
- **Macro:** `SHIFT_SAT_EN`.
- **Defined:**
  - During each SLA step, if r[W-1] ≠ r[W-2] before the step, set sticky ovf.
  - In DONE, if ovf = 1, `out_data` = 0x7F when the original sign bit is 0, or 0x80 when it is 1.
  - `out_ovf` = ovf.
- **Undefined:**
  - SLA is identical to SLL.
  - `out_ovf` is constant 0 and no overflow logic is built.

## Test plan
- **SRA:** op 2, data 0x90, amt 2, accept at edge k → `out_data` 0xE4, `out_valid` rises after edge k+2. Same input with op 1 (SRL) → 0x24.
- **Rotates:**
  - op 4 (ROL), data 0x81, amt 1 → 0x03.
  - op 5 (ROR), data 0x81, amt 3 → 0x30.
  - amt 0, any op → `out_data` = `in_data`, `out_valid` rises after edge k.
- **SLA:** op 3, data 0x30, amt 2.
  - With `SHIFT_SAT_EN`: → 0x7F, `out_ovf` 1.
  - Without it: → 0xC0, `out_ovf` 0.
  - Data 0xB0, amt 2, with `SHIFT_SAT_EN` → 0x80, `out_ovf` 1.
- **Backpressure:** hold `out_ready` 0 for 5 cycles in DONE → `out_valid`/`out_data` stable and `in_ready` 0. Raise `out_ready` → IDLE next cycle, `in_ready` 1.
- **Reset mid-shift:** op 1, amt 7, assert `rst` at edge k+3 → after that edge `out_valid` 0, `out_data` 0, `out_ovf` 0, and no result is ever emitted. A new request after `rst` deasserts completes normally.
- **Reserved op:** op 6, data 0x5A, amt 5 → `out_data` 0x5A, `out_valid` rises after edge k+5.

Source files
------------

// File: rtl/seq_shift_unit.sv
// -----------------------------------------------------------------------------
// seq_shift_unit
//
// Multi-cycle shift/rotate engine. One bit position is shifted per clock, so
// datapaths that cannot afford a barrel shifter can share this unit through a
// valid/ready handshake on both sides.
//
// Operations (in_op): 0 SLL, 1 SRL, 2 SRA, 3 SLA, 4 ROL, 5 ROR,
//                     6/7 reserved (operand passes through after amt cycles).
//
// Optional feature macro: SHIFT_SAT_EN
//   defined   : SLA tracks sticky overflow, saturates the result to the most
//               positive/negative value of the original sign, drives out_ovf.
//   undefined : SLA behaves as SLL and out_ovf is tied to 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   request present
//   in_ready   out  unit idle and able to accept (combinational: state, rst)
//   in_data    in   signed operand
//   in_amt     in   shift amount, 0..WIDTH-1
//   in_op      in   operation code
//   out_valid  out  result present (registered)
//   out_ready  in   consumer accepts result
//   out_data   out  signed result (registered)
//   out_ovf    out  SLA overflow flag (registered)
// -----------------------------------------------------------------------------
module seq_shift_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0]        in_amt,
    input  logic [2:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_ovf
);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_SLA = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t             r_state, w_state_d;
    logic [WIDTH-1:0]   r_data, w_data_d;
    logic [2:0]         r_op, w_op_d;
    logic [AMT_W-1:0]   r_cnt, w_cnt_d;
    logic               r_out_valid, w_out_valid_d;
    logic [WIDTH-1:0]   r_out_data, w_out_data_d;
    logic [WIDTH-1:0]   w_step;

`ifdef SHIFT_SAT_EN
    logic               r_sign, w_sign_d;
    logic               r_ovf, w_ovf_d;
    logic               r_out_ovf, w_out_ovf_d;
    logic [WIDTH-1:0]   w_sat;

    // Saturation target follows the sign of the operand as accepted.
    assign w_sat = r_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    // One single-bit step of the captured operation.
    always_comb begin
        w_step = r_data;
        unique case (r_op)
            OP_SLL, OP_SLA: w_step = {r_data[WIDTH-2:0], 1'b0};
            OP_SRL:         w_step = {1'b0, r_data[WIDTH-1:1]};
            OP_SRA:         w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            OP_ROL:         w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            OP_ROR:         w_step = {r_data[0], r_data[WIDTH-1:1]};
            default:        w_step = r_data;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_d     = r_state;
        w_data_d      = r_data;
        w_op_d        = r_op;
        w_cnt_d       = r_cnt;
        w_out_valid_d = r_out_valid;
        w_out_data_d  = r_out_data;
`ifdef SHIFT_SAT_EN
        w_sign_d      = r_sign;
        w_ovf_d       = r_ovf;
        w_out_ovf_d   = r_out_ovf;
`endif
        unique case (r_state)
            StIdle: begin
                if (in_valid && in_ready) begin
                    w_data_d = in_data;
                    w_op_d   = in_op;
                    w_cnt_d  = in_amt;
`ifdef SHIFT_SAT_EN
                    w_sign_d = in_data[WIDTH-1];
                    w_ovf_d  = 1'b0;
`endif
                    if (in_amt == '0) begin
                        // Zero amount: result is the operand, no overflow possible.
                        w_state_d     = StDone;
                        w_out_valid_d = 1'b1;
                        w_out_data_d  = in_data;
`ifdef SHIFT_SAT_EN
                        w_out_ovf_d   = 1'b0;
`endif
                    end else begin
                        w_state_d = StShift;
                    end
                end
            end
            StShift: begin
                w_data_d = w_step;
                w_cnt_d  = r_cnt - AMT_W'(1);
`ifdef SHIFT_SAT_EN
                // Sign change on a left step means the value no longer fits.
                if ((r_op == OP_SLA) && (r_data[WIDTH-1] != r_data[WIDTH-2])) begin
                    w_ovf_d = 1'b1;
                end
`endif
                if (r_cnt == AMT_W'(1)) begin
                    w_state_d     = StDone;
                    w_out_valid_d = 1'b1;
`ifdef SHIFT_SAT_EN
                    w_out_data_d  = w_ovf_d ? w_sat : w_step;
                    w_out_ovf_d   = w_ovf_d;
`else
                    w_out_data_d  = w_step;
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d     = StIdle;
                    w_out_valid_d = 1'b0;
                end
            end
            default: begin
                w_state_d     = StIdle;
                w_out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_data      <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_data      <= w_data_d;
            r_op        <= w_op_d;
            r_cnt       <= w_cnt_d;
            r_out_valid <= w_out_valid_d;
            r_out_data  <= w_out_data_d;
        end
    end

`ifdef SHIFT_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign    <= 1'b0;
            r_ovf     <= 1'b0;
            r_out_ovf <= 1'b0;
        end else begin
            r_sign    <= w_sign_d;
            r_ovf     <= w_ovf_d;
            r_out_ovf <= w_out_ovf_d;
        end
    end

    assign out_ovf = r_out_ovf;
`else
    assign out_ovf = 1'b0;
`endif

    assign in_ready  = (r_state == StIdle) && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_seq_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_unit
//
// Self-checking bench for seq_shift_unit (WIDTH 8). Expected results are
// queued when a request is accepted and compared when out_valid appears.
// Honours SHIFT_SAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_seq_shift_unit;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic [2:0]        in_amt;
    logic [2:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_data_q[$];
    logic       exp_ovf_q[$];
    int         exp_lat_q[$];

    seq_shift_unit #(
        .WIDTH (8),
        .AMT_W (3)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole-amount reference: returns {ovf, data}.
    function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] op,
                                         input int amt);
        logic signed [7:0] sd;
        logic [15:0]       dd;
        logic [7:0]        r;
        logic              ovf;
        logic [7:0]        top;
        logic [7:0]        mask;
        sd  = d;
        dd  = {d, d};
        ovf = 1'b0;
        case (op)
            3'd0: r = d << amt;
            3'd1: r = d >> amt;
            3'd2: r = sd >>> amt;
            3'd3: begin
                r = d << amt;
`ifdef SHIFT_SAT_EN
                // Overflow iff the top amt+1 bits are not all equal.
                top  = d >> (7 - amt);
                mask = 8'((1 << (amt + 1)) - 1);
                ovf  = (top != 8'h00) && (top != mask);
                if (ovf) r = d[7] ? 8'h80 : 8'h7F;
`else
                top  = 8'h00;
                mask = 8'h00;
`endif
            end
            3'd4: begin dd = dd << amt; r = dd[15:8]; end
            3'd5: begin dd = dd >> amt; r = dd[7:0]; end
            default: r = d;
        endcase
        return {ovf, r};
    endfunction

    // Issue one request and push its expectation.
    task automatic issue(input logic [7:0] d, input logic [2:0] op, input int amt,
                         input logic [7:0] exp_d, input logic exp_o);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_amt   = 3'(amt);
        exp_data_q.push_back(exp_d);
        exp_ovf_q.push_back(exp_o);
        exp_lat_q.push_back(amt);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for result, compare against scoreboard, optionally stall, then retire.
    task automatic collect(input int stall);
        int         cyc;
        logic [7:0] ed;
        logic       eo;
        int         el;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_data_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        ed = exp_data_q.pop_front();
        eo = exp_ovf_q.pop_front();
        el = exp_lat_q.pop_front();
        check("latency", cyc, el);
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("out_data", {24'd0, out_data}, {24'd0, ed});
        check("out_ovf", {31'd0, out_ovf}, {31'd0, eo});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {24'd0, out_data}, {24'd0, ed});
            check("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("retire_valid", {31'd0, out_valid}, 32'd0);
        check("retire_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input logic [7:0] d, input logic [2:0] op, input int amt,
                       input logic [7:0] exp_d, input logic exp_o, input int stall);
        issue(d, op, amt, exp_d, exp_o);
        collect(stall);
    endtask

    initial begin
        logic [8:0] m;
        logic [7:0] rd;
        logic [2:0] rop;
        int         ramt;
        int         seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors from the test plan.
        run(8'h90, 3'd2, 2, 8'hE4, 1'b0, 0);
        run(8'h90, 3'd1, 2, 8'h24, 1'b0, 0);
        run(8'h81, 3'd4, 1, 8'h03, 1'b0, 0);
        run(8'h81, 3'd5, 3, 8'h30, 1'b0, 0);
        run(8'hA7, 3'd2, 0, 8'hA7, 1'b0, 0);
        run(8'h3C, 3'd5, 0, 8'h3C, 1'b0, 0);
`ifdef SHIFT_SAT_EN
        run(8'h30, 3'd3, 2, 8'h7F, 1'b1, 0);
        run(8'hB0, 3'd3, 2, 8'h80, 1'b1, 0);
`else
        run(8'h30, 3'd3, 2, 8'hC0, 1'b0, 0);
`endif
        run(8'h5A, 3'd6, 5, 8'h5A, 1'b0, 0);
        // Backpressure: five stalled cycles in DONE.
        run(8'h0F, 3'd0, 3, 8'h78, 1'b0, 5);

        // Reset mid-shift: accept at edge k, reset sampled at edge k+3.
        in_valid = 1'b1;
        in_data  = 8'hF0;
        in_op    = 3'd1;
        in_amt   = 3'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out_data", {24'd0, out_data}, 32'd0);
        check("abort_out_ovf", {31'd0, out_ovf}, 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        run(8'h81, 3'd2, 4, 8'hF8, 1'b0, 1);

        // Random mix checked against the whole-amount model.
        for (int n = 0; n < 24; n++) begin
            rd   = 8'($urandom);
            rop  = 3'($urandom_range(0, 7));
            ramt = $urandom_range(0, 7);
            m    = model(rd, rop, ramt);
            run(rd, rop, ramt, m[7:0], m[8], $urandom_range(0, 2));
        end

        check("sb_drained", exp_data_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
